// File: rtl/uart_rx_packet.sv
// uart_rx_packet
//    Collects framed packets from a byte-wide UART receiver and replays the
//    payload through a valid/ready stream once the checksum is confirmed.
//    Frame: 0xA5, length L, L payload bytes, checksum C
//    where C = L ^ payload[0] ^ ... ^ payload[L-1].
//
//    state   | meaning
//    --------+-------------------------------------------------------------
//    IDLE    | hunting for the 0xA5 sync byte, everything else ignored
//    LEN     | waiting for the length byte
//    PAYLOAD | storing payload bytes into the buffer
//    CSUM    | waiting for the checksum byte
//    DRAIN   | presenting buffered payload on the output stream
//
// Ports
//    i_Clock        single clock, rising edge
//    i_Rst          synchronous active-high reset
//    i_RX_DV        one-cycle strobe, i_RX_Byte is valid
//    i_RX_Byte      received byte
//    o_Data_Valid   payload byte presented (high throughout DRAIN)
//    o_Data_Byte    payload byte
//    o_Data_Last    final payload byte, qualified by o_Data_Valid
//    i_Data_Ready   consumer ready; transfer when valid and ready
//    o_Pkt_Len      length of the packet being drained
//    o_Err_Len      pulse: length byte was 0 or above MAX_LEN
//    o_Err_Csum     pulse: checksum mismatch, packet discarded
//    o_Err_Timeout  pulse: inter-byte gap too long, packet discarded
//    o_Overrun      pulse: byte arrived during DRAIN and was dropped

module uart_rx_packet #(
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_CLKS = 21700
) (
    input  logic       i_Clock,
    input  logic       i_Rst,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_Data_Valid,
    output logic [7:0] o_Data_Byte,
    output logic       o_Data_Last,
    input  logic       i_Data_Ready,
    output logic [7:0] o_Pkt_Len,
    output logic       o_Err_Len,
    output logic       o_Err_Csum,
    output logic       o_Err_Timeout,
    output logic       o_Overrun
);

    localparam int              TMO_W     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
    localparam int              ADDR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]      SYNC_BYTE = 8'hA5;
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [7:0]        r_len;
    logic [7:0]        r_xor;
    logic [7:0]        r_wr_idx;
    logic [7:0]        r_rd_idx;
    logic [7:0]        r_pkt_len;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [7:0]        r_buf [0:MAX_LEN-1];

    logic              r_err_len;
    logic              r_err_csum;
    logic              r_err_tmo;
    logic              r_overrun;

    logic              w_len_ok;
    logic              w_tmo_hit;
    logic              w_xfer;
    logic              w_last;
    logic              w_load_len;
    logic              w_wr_en;
    logic              w_drain_start;
    logic              w_err_len;
    logic              w_err_csum;
    logic              w_err_tmo;
    logic              w_overrun;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [7:0]        w_rd_byte;

    assign w_wr_addr = r_wr_idx[ADDR_W-1:0];
    assign w_rd_addr = r_rd_idx[ADDR_W-1:0];
    assign w_rd_byte = r_buf[w_rd_addr];

    assign w_len_ok  = (i_RX_Byte != 8'd0) && (i_RX_Byte <= MAX_LEN_B);
    // A byte arriving in the terminal-count cycle wins over the timeout.
    assign w_tmo_hit = !i_RX_DV && (r_tmo_cnt == TMO_LAST);
    assign w_last    = (r_rd_idx == (r_len - 8'd1));
    assign w_xfer    = (r_state == DRAIN) && i_Data_Ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, datapath strobes and stream outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_load_len    = 1'b0;
        w_wr_en       = 1'b0;
        w_drain_start = 1'b0;
        w_err_len     = 1'b0;
        w_err_csum    = 1'b0;
        w_err_tmo     = 1'b0;
        w_overrun     = 1'b0;
        o_Data_Valid  = 1'b0;
        o_Data_Byte   = 8'h00;
        o_Data_Last   = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
                    w_state_nxt = LEN;
                end
            end

            LEN: begin
                if (i_RX_DV) begin
                    if (w_len_ok) begin
                        w_load_len  = 1'b1;
                        w_state_nxt = PAYLOAD;
                    end else begin
                        w_err_len   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_err_tmo   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            PAYLOAD: begin
                if (i_RX_DV) begin
                    w_wr_en = 1'b1;
                    if (r_wr_idx == (r_len - 8'd1)) begin
                        w_state_nxt = CSUM;
                    end
                end else if (w_tmo_hit) begin
                    w_err_tmo   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            CSUM: begin
                if (i_RX_DV) begin
                    if (i_RX_Byte == r_xor) begin
                        w_drain_start = 1'b1;
                        w_state_nxt   = DRAIN;
                    end else begin
                        w_err_csum  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_err_tmo   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end

            DRAIN: begin
                o_Data_Valid = 1'b1;
                o_Data_Byte  = w_rd_byte;
                o_Data_Last  = w_last;
                // Incoming bytes are dropped; state and buffer are untouched.
                if (i_RX_DV) begin
                    w_overrun = 1'b1;
                end
                if (w_xfer && w_last) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            r_len      <= 8'd0;
            r_xor      <= 8'd0;
            r_wr_idx   <= 8'd0;
            r_rd_idx   <= 8'd0;
            r_pkt_len  <= 8'd0;
            r_tmo_cnt  <= '0;
            r_err_len  <= 1'b0;
            r_err_csum <= 1'b0;
            r_err_tmo  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_err_len  <= w_err_len;
            r_err_csum <= w_err_csum;
            r_err_tmo  <= w_err_tmo;
            r_overrun  <= w_overrun;

            // Counter only runs while a frame is being assembled.
            if (i_RX_DV || (w_state_nxt == IDLE) || (w_state_nxt == DRAIN)) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if (w_load_len) begin
                r_len    <= i_RX_Byte;
                r_xor    <= i_RX_Byte;
                r_wr_idx <= 8'd0;
            end

            if (w_wr_en) begin
                r_xor    <= r_xor ^ i_RX_Byte;
                r_wr_idx <= r_wr_idx + 8'd1;
            end

            if (w_drain_start) begin
                r_pkt_len <= r_len;
                r_rd_idx  <= 8'd0;
            end

            if (w_xfer) begin
                r_rd_idx <= r_rd_idx + 8'd1;
            end
        end
    end

    // Payload storage carries no reset; it is always written before read.
    always_ff @(posedge i_Clock) begin
        if (w_wr_en) begin
            r_buf[w_wr_addr] <= i_RX_Byte;
        end
    end

    assign o_Pkt_Len     = r_pkt_len;
    assign o_Err_Len     = r_err_len;
    assign o_Err_Csum    = r_err_csum;
    assign o_Err_Timeout = r_err_tmo;
    assign o_Overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_packet.sv
// tb_uart_rx_packet
//    Directed bench for uart_rx_packet: good packet, backpressure, checksum
//    and length errors, timeout boundary, overrun and mid-packet reset.
//    Inputs are driven 1 ns after the rising edge; a monitor samples on the
//    falling edge and records stream transfers and pulse counts.

module tb_uart_rx_packet;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       rdy;
    logic       d_valid;
    logic [7:0] d_byte;
    logic       d_last;
    logic [7:0] pkt_len;
    logic       err_len;
    logic       err_csum;
    logic       err_tmo;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int dv_cyc;
    int prev_dv_cyc;
    int tmo_cyc;
    int ovr_cyc;
    int n_elen;
    int n_ecsum;
    int n_etmo;
    int n_ovr;
    int n_valid_cyc;
    logic [7:0] last_len;
    logic [8:0] rxq [$];
    int         xcyc [$];

    always #5 clk = ~clk;

    uart_rx_packet #(
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .i_Clock       (clk),
        .i_Rst         (rst),
        .i_RX_DV       (rx_dv),
        .i_RX_Byte     (rx_byte),
        .o_Data_Valid  (d_valid),
        .o_Data_Byte   (d_byte),
        .o_Data_Last   (d_last),
        .i_Data_Ready  (rdy),
        .o_Pkt_Len     (pkt_len),
        .o_Err_Len     (err_len),
        .o_Err_Csum    (err_csum),
        .o_Err_Timeout (err_tmo),
        .o_Overrun     (overrun)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (d_valid) n_valid_cyc++;
            if (d_valid && rdy) begin
                rxq.push_back({d_last, d_byte});
                xcyc.push_back(cyc);
                last_len = pkt_len;
            end
            if (err_len)  n_elen++;
            if (err_csum) n_ecsum++;
            if (err_tmo) begin
                n_etmo++;
                tmo_cyc = cyc;
            end
            if (overrun) begin
                n_ovr++;
                ovr_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        rxq.delete();
        xcyc.delete();
        n_elen      = 0;
        n_ecsum     = 0;
        n_etmo      = 0;
        n_ovr       = 0;
        n_valid_cyc = 0;
        last_len    = 8'h00;
        tmo_cyc     = -1;
        ovr_cyc     = -1;
    endtask

    // gap = extra idle cycles before the strobe; back-to-back calls with
    // gap 0 put strobes two cycles apart.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        @(posedge clk);
        #1;
        rx_dv       = 1'b1;
        rx_byte     = b;
        prev_dv_cyc = dv_cyc;
        dv_cyc      = cyc;
        @(posedge clk);
        #1;
        rx_dv       = 1'b0;
    endtask

    task automatic send_good3();
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h03, 0);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int n);
        logic [7:0] e [3];
        e[0] = b0;
        e[1] = b1;
        e[2] = b2;
        chk($sformatf("%s_count", tag), rxq.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < rxq.size()) begin
                chk($sformatf("%s_byte%0d", tag, i), rxq[i][7:0], e[i]);
                chk($sformatf("%s_last%0d", tag, i), rxq[i][8], (i == n - 1));
            end
        end
    endtask

    initial begin
        bit stable;
        rst     = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        rdy     = 1'b1;
        dv_cyc  = 0;
        clr_mon();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {d_valid, d_byte, d_last, pkt_len, err_len, err_csum, err_tmo, overrun}, 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Good packet, consumer always ready
        clr_mon();
        send_good3();
        chk("good_valid_after_csum", d_valid, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check_rx("good", 8'h11, 8'h22, 8'h33, 3);
        if (xcyc.size() == 3) chk("good_consecutive", xcyc[2] - xcyc[0], 2);
        chk("good_pkt_len", last_len, 8'd3);
        chk("good_no_err", n_elen + n_ecsum + n_etmo + n_ovr, 0);
        chk("good_valid_drops", d_valid, 1'b0);

        // Backpressure: hold off for 5 cycles
        clr_mon();
        rdy = 1'b0;
        send_good3();
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(d_valid && d_byte == 8'h11 && !d_last)) stable = 1'b0;
        end
        chk("bp_hold_stable", stable, 1'b1);
        @(posedge clk);
        #1;
        rdy = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_rx("bp", 8'h11, 8'h22, 8'h33, 3);

        // Bad checksum, then a good packet
        clr_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        send_byte(8'h00, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("csum_err_pulses", n_ecsum, 1);
        chk("csum_no_valid", n_valid_cyc, 0);
        send_good3();
        repeat (8) @(posedge clk);
        #1;
        check_rx("after_csum", 8'h11, 8'h22, 8'h33, 3);

        // Length errors: zero and MAX_LEN+1
        clr_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("len_zero_err", n_elen, 1);
        send_byte(8'hA5, 0);
        send_byte(8'h11, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("len_big_err", n_elen, 2);
        chk("len_no_valid", n_valid_cyc, 0);

        // Timeout after A5 02 AA and silence
        clr_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        repeat (TMO + 5) @(posedge clk);
        #1;
        chk("tmo_pulses", n_etmo, 1);
        chk("tmo_timing", tmo_cyc - dv_cyc, TMO + 1);
        chk("tmo_no_valid", n_valid_cyc, 0);

        // Byte arriving exactly at count TIMEOUT_CLKS-1 wins
        clr_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, TMO - 2);
        chk("edge_gap", dv_cyc - prev_dv_cyc, TMO);
        send_byte(8'hFD, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("edge_no_tmo", n_etmo, 0);
        check_rx("edge", 8'hAA, 8'h55, 8'h00, 2);

        // Overrun while draining under backpressure
        clr_mon();
        rdy = 1'b0;
        send_good3();
        send_byte(8'h77, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("ovr_pulses", n_ovr, 1);
        chk("ovr_timing", ovr_cyc - dv_cyc, 1);
        chk("ovr_hold_byte", {d_valid, d_byte}, {1'b1, 8'h11});
        rdy = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_rx("ovr", 8'h11, 8'h22, 8'h33, 3);

        // Reset mid-PAYLOAD
        clr_mon();
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs",
            {d_valid, d_byte, d_last, pkt_len, err_len, err_csum, err_tmo, overrun}, 32'h0);
        rst = 1'b0;
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h03, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_leftover_quiet", n_valid_cyc + n_elen + n_ecsum + n_etmo + n_ovr, 0);
        send_good3();
        repeat (8) @(posedge clk);
        #1;
        check_rx("after_rst", 8'h11, 8'h22, 8'h33, 3);
        chk("after_rst_len", last_len, 8'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
